// File: rtl/vending_mcn_multi.sv
// vending_mcn_multi: multi-product vending controller (coins in, selection/cancel, vend pulse, greedy 10/5/2/1 change out, registered outputs)
module vending_mcn_multi #(
  parameter int NPROD = 4,
  parameter int CREDIT_W = 8,
  parameter int MAX_CREDIT = 200,
  parameter logic [NPROD*CREDIT_W-1:0] PRICE_LIST = {8'd25, 8'd10, 8'd20, 8'd15}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [3:0]          coin_val,
  input  logic                sel_valid,
  input  logic [3:0]          sel_id,
  input  logic                cancel,
  output logic                vend,
  output logic [3:0]          vend_id,
  output logic                change_valid,
  output logic [3:0]          change_coin,
  output logic                coin_reject,
  output logic                sel_deny,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state
);
  typedef enum logic [1:0] {IDLE = 2'b00, CRED = 2'b01, VEND = 2'b10, CHNG = 2'b11} state_t;
  state_t st;
  logic [CREDIT_W-1:0] price, chg;
  logic [CREDIT_W:0] sum;
  logic coin_legal, can_ok, sel_ok, coin_ok;
  assign state = st;
  assign price = (32'(sel_id) < NPROD) ? PRICE_LIST[32'(sel_id)*CREDIT_W +: CREDIT_W] : '0;
  assign sum = {1'b0, credit} + {{(CREDIT_W-3){1'b0}}, coin_val};
  assign coin_legal = (coin_val == 4'd1 || coin_val == 4'd2 || coin_val == 4'd5 || coin_val == 4'd10) &&
                      sum <= (CREDIT_W+1)'(MAX_CREDIT);
  assign can_ok = st == CRED && cancel;
  assign sel_ok = st == CRED && !cancel && sel_valid && 32'(sel_id) < NPROD && credit >= price;
  assign coin_ok = (st == IDLE || st == CRED) && coin_valid && !can_ok && !sel_ok && coin_legal;
  assign chg = credit >= CREDIT_W'(10) ? CREDIT_W'(10) :
               credit >= CREDIT_W'(5)  ? CREDIT_W'(5)  :
               credit >= CREDIT_W'(2)  ? CREDIT_W'(2)  : CREDIT_W'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      credit <= '0;
      vend <= 1'b0;
      vend_id <= '0;
      change_valid <= 1'b0;
      change_coin <= '0;
      coin_reject <= 1'b0;
      sel_deny <= 1'b0;
    end else begin
      vend <= 1'b0;
      change_valid <= 1'b0;
      coin_reject <= coin_valid && !coin_ok;
      sel_deny <= sel_valid && !sel_ok;
      case (st)
        IDLE, CRED: begin
          if (can_ok) st <= CHNG;
          else if (sel_ok) begin
            st <= VEND;
            vend <= 1'b1;
            vend_id <= sel_id;
            credit <= credit - price;
          end else if (coin_ok) begin
            st <= CRED;
            credit <= sum[CREDIT_W-1:0];
          end
        end
        VEND: st <= credit == '0 ? IDLE : CHNG;
        CHNG: begin
          if (credit == '0) st <= IDLE;
          else begin
            change_valid <= 1'b1;
            change_coin <= chg[3:0];
            credit <= credit - chg;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vending_mcn_multi.sv
// tb_vending_mcn_multi: directed plus randomized checks of vending_mcn_multi against a queue-based reference model
module tb_vending_mcn_multi;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic coin_valid = 1'b0, sel_valid = 1'b0, cancel = 1'b0;
  logic [3:0] coin_val = '0, sel_id = '0;
  logic vend, change_valid, coin_reject, sel_deny;
  logic [3:0] vend_id, change_coin;
  logic [7:0] credit;
  logic [1:0] state;
  int checks = 0;
  int failures = 0;
  int m_state = 0;
  int m_credit = 0;
  int q[$];
  int prices[4] = '{15, 20, 10, 25};

  vending_mcn_multi dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_val(coin_val),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
    .vend(vend), .vend_id(vend_id), .change_valid(change_valid), .change_coin(change_coin),
    .coin_reject(coin_reject), .sel_deny(sel_deny), .credit(credit), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void greedy(input int c);
    int k;
    q.delete();
    while (c > 0) begin
      k = c >= 10 ? 10 : c >= 5 ? 5 : c >= 2 ? 2 : 1;
      q.push_back(k);
      c -= k;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; coin_val = '0; sel_id = '0;
    @(posedge clk);
    #1;
    m_state = 0; m_credit = 0; q.delete();
    chk("rst_state", 32'(state), 0);
    chk("rst_credit", 32'(credit), 0);
    chk("rst_vend", 32'(vend), 0);
    chk("rst_vend_id", 32'(vend_id), 0);
    chk("rst_change_valid", 32'(change_valid), 0);
    chk("rst_change_coin", 32'(change_coin), 0);
    chk("rst_coin_reject", 32'(coin_reject), 0);
    chk("rst_sel_deny", 32'(sel_deny), 0);
    rst = 1'b0;
  endtask

  task automatic step(input int cv, input int cval, input int sv, input int sid, input int can);
    int e_vend = 0, e_vid = 0, e_cv = 0, e_coin = 0, e_rej, e_deny, n_state, price;
    bit a_can, a_sel, a_coin, legal;
    @(negedge clk);
    coin_valid = cv != 0; coin_val = 4'(cval); sel_valid = sv != 0; sel_id = 4'(sid); cancel = can != 0;
    n_state = m_state;
    legal = (cval == 1 || cval == 2 || cval == 5 || cval == 10) && m_credit + cval <= 200;
    price = sid < 4 ? prices[sid] : 0;
    a_can = m_state == 1 && can != 0;
    a_sel = m_state == 1 && can == 0 && sv != 0 && sid < 4 && m_credit >= price;
    a_coin = m_state <= 1 && cv != 0 && legal && !a_can && !a_sel;
    e_rej = (cv != 0 && !a_coin) ? 1 : 0;
    e_deny = (sv != 0 && !a_sel) ? 1 : 0;
    if (a_can) begin
      n_state = 3;
      greedy(m_credit);
    end else if (a_sel) begin
      n_state = 2; m_credit -= price; e_vend = 1; e_vid = sid;
    end else if (a_coin) begin
      n_state = 1; m_credit += cval;
    end else if (m_state == 2) begin
      n_state = m_credit == 0 ? 0 : 3;
      greedy(m_credit);
    end else if (m_state == 3) begin
      if (q.size() == 0) n_state = 0;
      else begin
        e_coin = q.pop_front(); m_credit -= e_coin; e_cv = 1;
      end
    end
    m_state = n_state;
    @(posedge clk);
    #1;
    chk("state", 32'(state), m_state);
    chk("credit", 32'(credit), m_credit);
    chk("vend", 32'(vend), e_vend);
    chk("change_valid", 32'(change_valid), e_cv);
    chk("coin_reject", 32'(coin_reject), e_rej);
    chk("sel_deny", 32'(sel_deny), e_deny);
    if (e_vend != 0) chk("vend_id", 32'(vend_id), e_vid);
    if (e_cv != 0) chk("change_coin", 32'(change_coin), e_coin);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    do_reset();
    step(1, 5, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    chk("t1_credit15", 32'(credit), 15);
    step(0, 0, 1, 0, 0);
    chk("t1_vend", 32'(vend), 1);
    chk("t1_vend_id", 32'(vend_id), 0);
    idle(1);
    chk("t1_idle", 32'(state), 0);
    step(1, 10, 0, 0, 0);
    step(1, 10, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    chk("t2_vend_id", 32'(vend_id), 1);
    idle(3);
    chk("t2_idle", 32'(state), 0);
    step(1, 10, 0, 0, 0);
    step(0, 0, 1, 3, 0);
    chk("t3_deny", 32'(sel_deny), 1);
    step(0, 0, 0, 0, 1);
    idle(3);
    step(1, 10, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(6);
    chk("t4_idle", 32'(state), 0);
    step(1, 3, 0, 0, 0);
    for (int i = 0; i < 19; i++) step(1, 10, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    chk("t5_credit195", 32'(credit), 195);
    step(1, 10, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("t5_ceiling", 32'(credit), 200);
    step(1, 2, 1, 3, 0);
    chk("t5_vend_and_reject", 32'({vend, coin_reject}), 3);
    idle(22);
    step(1, 10, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(2);
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(int'($urandom_range(0, 1)), int'($urandom_range(0, 11)),
                int'($urandom_range(0, 5) == 0), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 14) == 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
